gpio_tx: RTL and testbench
==========================

# gpio_tx

Serial transmitter for the CPU's 32-bit `gpio` output word. It watches the parallel `gpio` bus and, whenever the value differs from the last word sent, shifts the new word out MSB-first on a 3-wire interface (`sclk`/`sdata`/`slatch`) compatible with a chain of 74HC595-style shift registers. It sits between `cpu.gpio` and the board pins and is the off-chip end of the GPIO interface.

## Interface
- `WIDTH`, 32: bits per word; must match the `gpio` width.
- `CLK_DIV`, 4: `clk` cycles per `sclk` half-period and per `slatch` pulse; must be ≥ 1.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `gpio`  in  WIDTH  parallel word from the CPU, sampled only in IDLE.
- `sclk`  out  1  serial clock; data is valid on its rising edge.
- `sdata`  out  1  serial data, MSB first.
- `slatch`  out  1  storage-latch pulse, high for `CLK_DIV` cycles after the last bit.
- `busy`  out  1  high while a word is in flight.

## Operation
- All outputs are registered.
- Internal state:
  - `last_sent[WIDTH-1:0]`
  - `shreg[WIDTH-1:0]`
  - bit counter, `$clog2(WIDTH)` bits
  - phase counter, `$clog2(CLK_DIV)` bits, minimum 1
  - state register
- States are IDLE, LOW, HIGH and LATCH.
- **IDLE**
  - On each edge, compare `gpio` with `last_sent`.
  - If they differ:
    - `shreg <= gpio`; `sdata <= gpio[WIDTH-1]`; `sclk <= 0`; `busy <= 1`.
    - Clear both counters.
    - Go to LOW.
  - If they are equal, stay in IDLE.
- **LOW**
  - `sclk = 0` for `CLK_DIV` cycles.
  - Then `sclk <= 1` and go to HIGH.
- **HIGH**
  - `sclk = 1` for `CLK_DIV` cycles.
  - Then `sclk <= 0`.
  - If the bit counter is `WIDTH-1`:
    - `slatch <= 1`; `sdata <= 0`.
    - Go to LATCH.
  - Otherwise:
    - Shift `shreg` left by 1.
    - `sdata <=` the next bit.
    - Increment the bit counter.
    - Go to LOW.
- **LATCH**
  - `slatch = 1` for `CLK_DIV` cycles.
  - Then `slatch <= 0`; `busy <= 0`; `last_sent <=` the word just sent.
  - Go to IDLE.
- Changes to `gpio` while `busy` is high are ignored.
  - After returning to IDLE, the block compares `gpio` with `last_sent` again.
  - The final stable `gpio` value is therefore always sent; intermediate values may be dropped.
- The first word after reset is sent only if `gpio != 0`, because `last_sent` resets to 0.
- Reset mid-transfer:
  - The transfer is aborted immediately; no `slatch` pulse is emitted.
  - `last_sent` returns to 0.

## Timing
- Reset values: `sclk = 0`, `sdata = 0`, `slatch = 0`, `busy = 0`, state IDLE, `last_sent = 0`, `shreg = 0`.
- Start of a transfer:
  - `gpio` change is sampled at edge N.
  - `busy` and `sdata = MSB` are visible after edge N.
  - The first `sclk` rise is at edge N+`CLK_DIV`.
- Bit k (k = 0 is the MSB) rises on `sclk` at edge N + (2k+1)·`CLK_DIV`.
- `sdata` changes only on `sclk` falling edges, giving `CLK_DIV` cycles of setup and hold.
- `slatch` rises at N + 2·`WIDTH`·`CLK_DIV` and falls at N + (2·`WIDTH`+1)·`CLK_DIV`.
- `busy` falls at the same edge as `slatch`.
- Busy duration is (2·`WIDTH`+1)·`CLK_DIV` cycles; with the defaults this is 260 cycles.
- Back-to-back transfers: the earliest next start is 1 cycle after `busy` falls, i.e. one IDLE cycle minimum.
- `CLK_DIV = 1`: each phase lasts 1 cycle and `sclk` runs at `clk`/2.

## Structure
- Single flat module; no sub-module is natural, since the phase counter is a few lines.
- State encodings (IDLE=0, LOW=1, HIGH=2, LATCH=3) go in the shared header `gpio_defs.vh` as localparams, so a future `gpio_rx` can reuse them.
- `WIDTH` and `CLK_DIV` defaults also live in `gpio_defs.vh`.

## Test plan
- **Reset and no-change:** hold `rst` high, then release with `gpio = 0`. Required: every output stays 0 for 300 cycles.
- **Single word:** `gpio = 32'hA5A5_0F0F` (defaults). Required:
  - Bits sampled on `sclk` rises equal `A5A50F0F` MSB-first.
  - Exactly 32 `sclk` rises.
  - `slatch` is high for 4 cycles starting at cycle 256 after the start edge.
  - `busy` is high for exactly 260 cycles.
- **Change during busy:** `gpio = 1`, then `gpio = 2` at cycle 50 and `gpio = 3` at cycle 100. Required:
  - Exactly two transfers occur, carrying 1 then 3.
  - The second starts 1 cycle after `busy` falls.
- **Same value rewritten:** after 1 is sent, drive `gpio = 1` again. Required: no new transfer.
- **Reset mid-transfer:** assert `rst` at cycle 40 of a transfer. Required:
  - All outputs are 0 within the same cycle (asynchronous).
  - There is no `slatch` pulse.
  - After release, the same nonzero `gpio` is retransmitted in full.
- **`CLK_DIV = 1`, `WIDTH = 8`:** `gpio = 8'h81`. Required:
  - `sclk` toggles every cycle.
  - Bits sent are 1,0,0,0,0,0,0,1.
  - `busy` is high for 17 cycles.

Source files
------------

// File: rtl/gpio_tx_pkg.sv
// gpio_tx_pkg
// Shared definitions for the serial GPIO interface: default word width and
// serial clock divider, plus the transmitter state encoding. Kept in a
// package so a future receiver can reuse the same encodings.
package gpio_tx_pkg;

    // Default bits per word (matches the CPU gpio bus width).
    localparam int GPIO_WIDTH_DEF   = 32;

    // Default clk cycles per sclk half-period and per slatch pulse.
    localparam int GPIO_CLK_DIV_DEF = 4;

    // Transmitter states: IDLE=0, LOW=1, HIGH=2, LATCH=3.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOW   = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LATCH = 2'd3
    } gpio_state_t;

endpackage

// File: rtl/gpio_tx.sv
// gpio_tx
// Serial transmitter for the CPU's parallel gpio word. Whenever gpio differs
// from the last word sent, the new word is shifted out MSB-first on a 3-wire
// 74HC595-compatible interface, followed by a storage-latch pulse.
//
// Ports:
//   clk     in   1      system clock, rising edge
//   rst     in   1      asynchronous active-high reset
//   gpio    in   WIDTH  parallel word, sampled only while idle
//   sclk    out  1      serial clock, data valid on its rising edge
//   sdata   out  1      serial data, MSB first
//   slatch  out  1      latch pulse, CLK_DIV cycles after the last bit
//   busy    out  1      high while a word is in flight
module gpio_tx
    import gpio_tx_pkg::*;
#(
    parameter int WIDTH   = GPIO_WIDTH_DEF,
    parameter int CLK_DIV = GPIO_CLK_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] gpio,
    output logic             sclk,
    output logic             sdata,
    output logic             slatch,
    output logic             busy
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    gpio_state_t      state_r;
    logic [WIDTH-1:0] last_sent_r;
    logic [WIDTH-1:0] shreg_r;
    logic [BW-1:0]    bit_cnt_r;
    logic [PW-1:0]    phase_r;
    logic [WIDTH-1:0] shreg_rot_s;
    logic             phase_done_s;

    // The shift register rotates rather than shifts: after WIDTH rotations it
    // holds the original word again, which becomes last_sent without needing
    // a separate copy of the word in flight.
    assign shreg_rot_s  = (shreg_r << 1) | (shreg_r >> (WIDTH - 1));
    assign phase_done_s = (phase_r == PH_LAST);

    // Transmit FSM: change detection, bit sequencing and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            last_sent_r <= {WIDTH{1'b0}};
            shreg_r     <= {WIDTH{1'b0}};
            bit_cnt_r   <= {BW{1'b0}};
            phase_r     <= {PW{1'b0}};
            sclk        <= 1'b0;
            sdata       <= 1'b0;
            slatch      <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (gpio != last_sent_r) begin
                        shreg_r   <= gpio;
                        sdata     <= gpio[WIDTH-1];
                        sclk      <= 1'b0;
                        busy      <= 1'b1;
                        bit_cnt_r <= {BW{1'b0}};
                        phase_r   <= {PW{1'b0}};
                        state_r   <= ST_LOW;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end

                ST_LOW: begin
                    if (phase_done_s) begin
                        phase_r <= {PW{1'b0}};
                        sclk    <= 1'b1;
                        state_r <= ST_HIGH;
                    end else begin
                        phase_r <= phase_r + 1'b1;
                    end
                end

                ST_HIGH: begin
                    if (phase_done_s) begin
                        phase_r <= {PW{1'b0}};
                        sclk    <= 1'b0;
                        shreg_r <= shreg_rot_s;
                        if (bit_cnt_r == BIT_LAST) begin
                            slatch  <= 1'b1;
                            sdata   <= 1'b0;
                            state_r <= ST_LATCH;
                        end else begin
                            sdata     <= shreg_rot_s[WIDTH-1];
                            bit_cnt_r <= bit_cnt_r + 1'b1;
                            state_r   <= ST_LOW;
                        end
                    end else begin
                        phase_r <= phase_r + 1'b1;
                    end
                end

                ST_LATCH: begin
                    if (phase_done_s) begin
                        phase_r     <= {PW{1'b0}};
                        slatch      <= 1'b0;
                        busy        <= 1'b0;
                        last_sent_r <= shreg_r;
                        state_r     <= ST_IDLE;
                    end else begin
                        phase_r <= phase_r + 1'b1;
                    end
                end

                default: begin
                    // Unreachable encoding: fall back to a quiet idle line.
                    state_r <= ST_IDLE;
                    phase_r <= {PW{1'b0}};
                    sclk    <= 1'b0;
                    sdata   <= 1'b0;
                    slatch  <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_tx.sv
// tb_gpio_tx
// Directed bench for gpio_tx: a default 32-bit / CLK_DIV=4 instance and an
// 8-bit / CLK_DIV=1 instance sharing clock and reset.
module tb_gpio_tx;

    logic        clk;
    logic        rst;
    logic [31:0] gpio;
    logic [7:0]  gpio8;
    logic        sclk, sdata, slatch, busy;
    logic        sclk8, sdata8, slatch8, busy8;
    logic        sel8;
    logic        m_sclk, m_sdata, m_slatch, m_busy;

    int n_checks;
    int n_pass;

    gpio_tx dut (
        .clk    (clk),
        .rst    (rst),
        .gpio   (gpio),
        .sclk   (sclk),
        .sdata  (sdata),
        .slatch (slatch),
        .busy   (busy)
    );

    gpio_tx #(.WIDTH(8), .CLK_DIV(1)) dut8 (
        .clk    (clk),
        .rst    (rst),
        .gpio   (gpio8),
        .sclk   (sclk8),
        .sdata  (sdata8),
        .slatch (slatch8),
        .busy   (busy8)
    );

    // Observe either instance through one set of wires.
    assign m_sclk   = sel8 ? sclk8   : sclk;
    assign m_sdata  = sel8 ? sdata8  : sdata;
    assign m_slatch = sel8 ? slatch8 : slatch;
    assign m_busy   = sel8 ? busy8   : busy;

    // 10 ns system clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait for a transfer to start, then record it until busy falls.
    // Times are in cycles after the start edge; c1t/c2t (nonzero) rewrite gpio mid-transfer.
    task automatic run_xfer(input int c1t, input logic [31:0] c1v,
                            input int c2t, input logic [31:0] c2v,
                            output logic [31:0] word, output int nrise,
                            output int nsw, output int lstart, output int llen,
                            output int blen, output int wait_n);
        logic prev;
        int   t;
        word = 32'd0; nrise = 0; nsw = 0; lstart = -1; llen = 0; blen = -1; wait_n = 0;
        while (!m_busy && wait_n < 20) begin
            step();
            wait_n++;
        end
        if (!m_busy) begin
            check("start_timeout", 32'd0, 32'd1);
            return;
        end
        prev = m_sclk;
        t = 0;
        while (t < 2000) begin
            step();
            t++;
            if (t == c1t) gpio = c1v;
            if (t == c2t) gpio = c2v;
            if (m_sclk != prev) nsw++;
            if (m_sclk && !prev) begin
                word = {word[30:0], m_sdata};
                nrise++;
            end
            prev = m_sclk;
            if (m_slatch) begin
                if (lstart < 0) lstart = t;
                llen++;
            end
            if (!m_busy) begin
                blen = t;
                break;
            end
        end
        if (blen < 0) check("busy_timeout", 32'd0, 32'd1);
    endtask

    task automatic quiet(input string tag, input int cycles);
        int bad;
        bad = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if ({sclk, sdata, slatch, busy, sclk8, sdata8, slatch8, busy8} != 8'd0) bad++;
        end
        check(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        logic [31:0] w;
        int nr, ns, ls, ll, bl, wn;
        int seen_latch;

        n_checks = 0;
        n_pass   = 0;
        sel8  = 1'b0;
        rst   = 1'b1;
        gpio  = 32'd0;
        gpio8 = 8'd0;

        // Reset state and no-change idle
        repeat (3) step();
        check("rst_outs", {28'd0, sclk, sdata, slatch, busy}, 32'd0);
        check("rst_outs8", {28'd0, sclk8, sdata8, slatch8, busy8}, 32'd0);
        rst = 1'b0;
        quiet("idle_quiet", 300);

        // Single word
        gpio = 32'hA5A5_0F0F;
        run_xfer(0, 32'd0, 0, 32'd0, w, nr, ns, ls, ll, bl, wn);
        check("word_a5a5", w, 32'hA5A5_0F0F);
        check("rises_32", 32'(nr), 32'd32);
        check("sclk_toggles_64", 32'(ns), 32'd64);
        check("latch_start", 32'(ls), 32'd256);
        check("latch_len", 32'(ll), 32'd4);
        check("busy_len", 32'(bl), 32'd260);

        // Change during busy: 1, then 2 at cycle 50 and 3 at cycle 100
        gpio = 32'd1;
        run_xfer(50, 32'd2, 100, 32'd3, w, nr, ns, ls, ll, bl, wn);
        check("chg_word1", w, 32'd1);
        check("chg_busy1", 32'(bl), 32'd260);
        run_xfer(0, 32'd0, 0, 32'd0, w, nr, ns, ls, ll, bl, wn);
        check("chg_word2", w, 32'd3);
        check("chg_gap", 32'(wn), 32'd1);
        check("chg_rises2", 32'(nr), 32'd32);
        quiet("chg_no_third", 300);

        // Same value rewritten
        gpio = 32'd1;
        run_xfer(0, 32'd0, 0, 32'd0, w, nr, ns, ls, ll, bl, wn);
        check("same_first", w, 32'd1);
        gpio = 32'd1;
        quiet("same_no_xfer", 300);

        // Reset mid-transfer at cycle 40
        gpio = 32'hDEAD_BEEF;
        wn = 0;
        while (!busy && wn < 20) begin
            step();
            wn++;
        end
        check("mid_started", {31'd0, busy}, 32'd1);
        seen_latch = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (slatch) seen_latch++;
        end
        check("mid_busy_before_rst", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_async", {28'd0, sclk, sdata, slatch, busy}, 32'd0);
        check("mid_no_latch", 32'(seen_latch), 32'd0);
        step();
        step();
        rst = 1'b0;
        run_xfer(0, 32'd0, 0, 32'd0, w, nr, ns, ls, ll, bl, wn);
        check("mid_resend_word", w, 32'hDEAD_BEEF);
        check("mid_resend_rises", 32'(nr), 32'd32);
        check("mid_resend_latch", 32'(ll), 32'd4);
        check("mid_resend_busy", 32'(bl), 32'd260);

        // 8-bit instance, CLK_DIV = 1
        sel8  = 1'b1;
        gpio8 = 8'h81;
        run_xfer(0, 32'd0, 0, 32'd0, w, nr, ns, ls, ll, bl, wn);
        check("w8_word", w, 32'h81);
        check("w8_rises", 32'(nr), 32'd8);
        check("w8_toggles", 32'(ns), 32'd16);
        check("w8_busy", 32'(bl), 32'd17);
        check("w8_latch_start", 32'(ls), 32'd16);
        check("w8_latch_len", 32'(ll), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
